data_sram_responder: RTL and testbench

Responder end of the CPU data SRAM interface: accepts `data_sram_*` requests from the core and returns read data one cycle later. Backs a word-addressed RAM with per-byte write enables and decodes a small MMIO register window (LED, switch, scratch, free-running timer). Sits directly under the SoC top, next to the instruction RAM, wired to the core's data port.

---
 rtl/soc_map_pkg.sv | 24 ++
 rtl/sram_bank_be.sv | 33 +++
 rtl/data_sram_responder.sv | 124 ++++++++++++
 tb/tb_data_sram_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/soc_map_pkg.sv
// rtl/soc_map_pkg.sv - SoC address map constants and byte-lane merge helper
package soc_map_pkg;

  localparam logic [31:0] MMIO_BASE_DEF = 32'hbfaf_f000;

  localparam logic [11:0] LED_OFS     = 12'h000;
  localparam logic [11:0] SW_OFS      = 12'h004;
  localparam logic [11:0] SCRATCH_OFS = 12'h008;
  localparam logic [11:0] TIMER_OFS   = 12'h00c;

  localparam int LED_W = 16;
  localparam int SW_W  = 8;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_bank_be.sv
// rtl/sram_bank_be.sv - single-port word RAM with byte write enables and registered read
module sram_bank_be #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] rdata_q;

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (rd_en) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data SRAM responder: RAM plus MMIO window (LED, switch, scratch, timer)
// Optional free-running timer at offset 0x00c enabled by DATA_SRAM_TIMER_EN.
module data_sram_responder
  import soc_map_pkg::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_sram_en,
  input  logic [3:0]       data_sram_we,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic [31:0]      data_sram_rdata,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led
);

  logic        mmio_hit;
  logic        rd_req;
  logic        wr_req;
  logic [9:0]  reg_sel;
  logic [31:0] ram_rdata;
  logic [31:0] mmio_val;

  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      scratch_q, scratch_d;
  logic [31:0]      mmio_rdata_q, mmio_rdata_d;
  logic             rsel_ram_q, rsel_ram_d;

`ifdef DATA_SRAM_TIMER_EN
  logic [31:0] timer_q, timer_d;
`endif

  assign mmio_hit = (data_sram_addr[31:12] == MMIO_BASE[31:12]);
  assign rd_req   = data_sram_en && (data_sram_we == 4'b0000);
  assign wr_req   = data_sram_en && (data_sram_we != 4'b0000);
  assign reg_sel  = data_sram_addr[11:2];

  sram_bank_be #(
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk   (clk),
    .wr_en (wr_req && !mmio_hit && !reset),
    .rd_en (rd_req && !mmio_hit && !reset),
    .be    (data_sram_we),
    .addr  (data_sram_addr[ADDR_W+1:2]),
    .wdata (data_sram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    mmio_val = '0;
    case (reg_sel)
      LED_OFS[11:2]:     mmio_val = {{(32-LED_W){1'b0}}, led_q};
      SW_OFS[11:2]:      mmio_val = {{(32-SW_W){1'b0}}, sw};
      SCRATCH_OFS[11:2]: mmio_val = scratch_q;
`ifdef DATA_SRAM_TIMER_EN
      TIMER_OFS[11:2]:   mmio_val = timer_q;
`endif
      default:           mmio_val = '0;
    endcase
  end

  always_comb begin
    led_d        = led_q;
    scratch_d    = scratch_q;
    rsel_ram_d   = rsel_ram_q;
    mmio_rdata_d = mmio_rdata_q;

    if (wr_req && mmio_hit) begin
      if (reg_sel == LED_OFS[11:2]) begin
        led_d = LED_W'(be_merge({{(32-LED_W){1'b0}}, led_q}, data_sram_wdata, data_sram_we));
      end
      if (reg_sel == SCRATCH_OFS[11:2]) begin
        scratch_d = be_merge(scratch_q, data_sram_wdata, data_sram_we);
      end
    end

    // The MMIO value is captured at the read edge so rdata holds it like a RAM read.
    if (rd_req) begin
      rsel_ram_d = !mmio_hit;
      if (mmio_hit) begin
        mmio_rdata_d = mmio_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q        <= '0;
      scratch_q    <= '0;
      mmio_rdata_q <= '0;
      rsel_ram_q   <= 1'b0;
    end else begin
      led_q        <= led_d;
      scratch_q    <= scratch_d;
      mmio_rdata_q <= mmio_rdata_d;
      rsel_ram_q   <= rsel_ram_d;
    end
  end

`ifdef DATA_SRAM_TIMER_EN
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (wr_req && mmio_hit && (reg_sel == TIMER_OFS[11:2])) begin
      timer_d = be_merge(timer_q, data_sram_wdata, data_sram_we);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  assign data_sram_rdata = rsel_ram_q ? ram_rdata : mmio_rdata_q;
  assign led             = led_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - table-driven and randomized bench for data_sram_responder
module tb_data_sram_responder;

  localparam int AW = 14;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [7:0]  sw;
  logic [15:0] led;

  int n_checks = 0;
  int n_errors = 0;

  data_sram_responder #(.ADDR_W(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .sw              (sw),
    .led             (led)
  );

  always #5 clk = ~clk;

  // Reference state: what the spec says each register and RAM word holds.
  logic [31:0] ram_m [int];
  logic [15:0] led_m;
  logic [31:0] scratch_m;
  logic [31:0] timer_m;
  logic [31:0] rdata_m;
  logic        rdata_known;

  typedef struct {
    string       name;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  swv;
    logic [31:0] exp_rdata;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mmio_rd(input logic [11:0] ofs, input logic [7:0] swv);
    logic [31:0] v;
    case (ofs & 12'hffc)
      12'h000: v = {16'h0, led_m};
      12'h004: v = {24'h0, swv};
      12'h008: v = scratch_m;
`ifdef DATA_SRAM_TIMER_EN
      12'h00c: v = timer_m;
`endif
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic model_edge(input logic rst, input logic en, input logic [3:0] we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [7:0] swv);
    int          idx;
    logic [31:0] t_next;
    idx    = int'((addr >> 2) % (32'd1 << AW));
    t_next = timer_m + 32'd1;
    if (rst) begin
      rdata_m     = 32'h0;
      rdata_known = 1'b1;
      led_m       = 16'h0;
      scratch_m   = 32'h0;
      t_next      = 32'h0;
    end else if (en) begin
      if (addr[31:12] == 20'hbfaff) begin
        if (we == 4'h0) begin
          rdata_m     = mmio_rd(addr[11:0], swv);
          rdata_known = 1'b1;
        end else begin
          case (addr[11:2])
            10'd0: led_m = 16'(merge({16'h0, led_m}, wdata, we));
            10'd2: scratch_m = merge(scratch_m, wdata, we);
`ifdef DATA_SRAM_TIMER_EN
            10'd3: t_next = merge(timer_m, wdata, we);
`endif
            default: ;
          endcase
        end
      end else if (we == 4'h0) begin
        rdata_known = ram_m.exists(idx);
        if (rdata_known) rdata_m = ram_m[idx];
      end else begin
        ram_m[idx] = merge(ram_m.exists(idx) ? ram_m[idx] : 32'h0, wdata, we);
      end
    end
    timer_m = t_next;
  endtask

  task automatic step(input logic rst, input logic en, input logic [3:0] we,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [7:0] swv);
    reset           = rst;
    data_sram_en    = en;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    sw              = swv;
    model_edge(rst, en, we, addr, wdata, swv);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic add(input string name, input logic en, input logic [3:0] we,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [7:0] swv,
                     input logic [31:0] exp_rdata, input logic [15:0] exp_led);
    vec_t v;
    v.name = name; v.en = en; v.we = we; v.addr = addr; v.wdata = wdata;
    v.swv = swv; v.exp_rdata = exp_rdata; v.exp_led = exp_led;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    logic        e;
    logic        r;
    int          sel;
    logic [11:0] ofs_tab [7];

    ofs_tab = '{12'h000, 12'h004, 12'h008, 12'h00c, 12'h010, 12'h014, 12'hffc};
    timer_m = 32'h0; led_m = 16'h0; scratch_m = 32'h0; rdata_m = 32'h0; rdata_known = 1'b0;

    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 8'h00);
    step(1'b1, 1'b1, 4'hf, 32'h0000_0000, 32'h5555_5555, 8'h00);
    chk("reset_rdata", data_sram_rdata, 32'h0);
    chk("reset_led", {16'h0, led}, 32'h0);

    add("ram_wr0",    1, 4'hf, 32'h0000_0000, 32'h1122_3344, 8'h00, 32'h0000_0000, 16'h0000);
    add("ram_rd0",    1, 4'h0, 32'h0000_0000, 32'h0,         8'h00, 32'h1122_3344, 16'h0000);
    add("wr100_full", 1, 4'hf, 32'h0000_0100, 32'haabb_ccdd, 8'h00, 32'h1122_3344, 16'h0000);
    add("wr100_part", 1, 4'h5, 32'h0000_0100, 32'h0000_eeff, 8'h00, 32'h1122_3344, 16'h0000);
    add("rd100",      1, 4'h0, 32'h0000_0100, 32'h0,         8'h00, 32'haa00_ccff, 16'h0000);
    add("wr104",      1, 4'hf, 32'h0000_0104, 32'h5566_7788, 8'h00, 32'haa00_ccff, 16'h0000);
    add("b2b_rd100",  1, 4'h0, 32'h0000_0100, 32'h0,         8'h00, 32'haa00_ccff, 16'h0000);
    add("b2b_rd104",  1, 4'h0, 32'h0000_0104, 32'h0,         8'h00, 32'h5566_7788, 16'h0000);
    add("led_wr",     1, 4'hf, 32'hbfaf_f000, 32'h0001_5a5a, 8'h00, 32'h5566_7788, 16'h5a5a);
    add("led_rd",     1, 4'h0, 32'hbfaf_f000, 32'h0,         8'h00, 32'h0000_5a5a, 16'h5a5a);
    add("sw_rd",      1, 4'h0, 32'hbfaf_f004, 32'h0,         8'h3c, 32'h0000_003c, 16'h5a5a);
    add("hole_rd",    1, 4'h0, 32'hbfaf_f010, 32'h0,         8'h3c, 32'h0000_0000, 16'h5a5a);
    add("scr_wr",     1, 4'hf, 32'hbfaf_f008, 32'hcafe_f00d, 8'h00, 32'h0000_0000, 16'h5a5a);
    add("scr_part",   1, 4'h8, 32'hbfaf_f008, 32'h1234_5678, 8'h00, 32'h0000_0000, 16'h5a5a);
    add("scr_rd",     1, 4'h0, 32'hbfaf_f008, 32'h0,         8'h00, 32'h12fe_f00d, 16'h5a5a);
    add("idle_hold",  0, 4'hf, 32'hbfaf_f000, 32'hffff_ffff, 8'h00, 32'h12fe_f00d, 16'h5a5a);
    add("led_lane1",  1, 4'h2, 32'hbfaf_f000, 32'h0000_a500, 8'h00, 32'h12fe_f00d, 16'ha55a);
    add("sw_wr_ign",  1, 4'hf, 32'hbfaf_f004, 32'hffff_ffff, 8'h3c, 32'h12fe_f00d, 16'ha55a);
    add("sw_rd2",     1, 4'h0, 32'hbfaf_f004, 32'h0,         8'h3c, 32'h0000_003c, 16'ha55a);
    add("hole_wr",    1, 4'hf, 32'hbfaf_f010, 32'hffff_ffff, 8'h00, 32'h0000_003c, 16'ha55a);
    add("hole_rd2",   1, 4'h0, 32'hbfaf_f010, 32'h0,         8'h00, 32'h0000_0000, 16'ha55a);
    add("alias_rd",   1, 4'h0, 32'h0001_0100, 32'h0,         8'h00, 32'haa00_ccff, 16'ha55a);
    add("led_lowbit", 1, 4'h0, 32'hbfaf_f002, 32'h0,         8'h00, 32'h0000_a55a, 16'ha55a);
`ifdef DATA_SRAM_TIMER_EN
    add("tmr_wr",     1, 4'hf, 32'hbfaf_f00c, 32'hffff_fffe, 8'h00, 32'h0000_a55a, 16'ha55a);
    add("tmr_rd",     1, 4'h0, 32'hbfaf_f00c, 32'h0,         8'h00, 32'hffff_fffe, 16'ha55a);
    add("tmr_idle",   0, 4'h0, 32'h0000_0000, 32'h0,         8'h00, 32'hffff_fffe, 16'ha55a);
    add("tmr_wrap",   1, 4'h0, 32'hbfaf_f00c, 32'h0,         8'h00, 32'h0000_0000, 16'ha55a);
`else
    add("tmr_wr_ign", 1, 4'hf, 32'hbfaf_f00c, 32'hffff_fffe, 8'h00, 32'h0000_a55a, 16'ha55a);
    add("tmr_rd_off", 1, 4'h0, 32'hbfaf_f00c, 32'h0,         8'h00, 32'h0000_0000, 16'ha55a);
`endif

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].swv);
      chk({vecs[i].name, "_rdata"}, data_sram_rdata, vecs[i].exp_rdata);
      chk({vecs[i].name, "_led"}, {16'h0, led}, {16'h0, vecs[i].exp_led});
    end

    // Reset must drop a same-cycle write to both a register and RAM.
    step(1'b0, 1'b1, 4'hf, 32'hbfaf_f008, 32'hdead_beef, 8'h00);
    step(1'b0, 1'b1, 4'hf, 32'h0000_0200, 32'h0bad_cafe, 8'h00);
    step(1'b0, 1'b1, 4'h0, 32'h0000_0200, 32'h0,         8'h00);
    chk("pre_rst_ram", data_sram_rdata, 32'h0bad_cafe);
    step(1'b1, 1'b1, 4'hf, 32'hbfaf_f008, 32'h1234_5678, 8'h00);
    chk("rst_wr_rdata", data_sram_rdata, 32'h0);
    chk("rst_wr_led", {16'h0, led}, 32'h0);
    step(1'b1, 1'b1, 4'hf, 32'h0000_0200, 32'h1111_1111, 8'h00);
    step(1'b0, 1'b1, 4'h0, 32'hbfaf_f008, 32'h0,         8'h00);
    chk("rst_scratch", data_sram_rdata, 32'h0);
    step(1'b0, 1'b1, 4'h0, 32'h0000_0200, 32'h0,         8'h00);
    chk("rst_ram_kept", data_sram_rdata, 32'h0bad_cafe);

    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 4'hf, 32'(i * 4), $urandom(), 8'h00);
    end

    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 2));
      if (sel == 0) begin
        a = {20'hbfaff, ofs_tab[$urandom_range(0, 6)]} | 32'($urandom_range(0, 3));
      end else begin
        a = ($urandom() & 32'hffff_0000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      end
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      e = ($urandom_range(0, 7) != 0);
      r = ($urandom_range(0, 63) == 0);
      step(r, e, w, a, $urandom(), 8'($urandom()));
      if (rdata_known) chk("rand_rdata", data_sram_rdata, rdata_m);
      chk("rand_led", {16'h0, led}, {16'h0, led_m});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
